// File: rtl/n163_wave_sequencer.sv
// Namco 163 wavetable channel sequencer: shares the 128x8 sound RAM between the CPU
// data port and a per-slot phase-update / sample-fetch engine.
module n163_wave_sequencer #(
    parameter int SLOT_TICKS = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       m2_ce,
    input  logic       halt,
    input  logic       cpu_req,
    input  logic       cpu_we,
    input  logic [6:0] cpu_addr,
    input  logic [7:0] cpu_wdata,
    output logic [7:0] cpu_rdata,
    output logic       cpu_ack,
    output logic [6:0] ram_addr,
    output logic       ram_we,
    output logic [7:0] ram_wdata,
    input  logic [7:0] ram_rdata,
    output logic       smp_valid,
    output logic [2:0] smp_ch,
    output logic [7:0] smp_out
);
    localparam logic [3:0] S_IDLE = 4'd0,  S_RF0 = 4'd1,  S_RP0 = 4'd2,  S_RF1 = 4'd3;
    localparam logic [3:0] S_RP1  = 4'd4,  S_RF2 = 4'd5,  S_RP2 = 4'd6,  S_RWAV = 4'd7;
    localparam logic [3:0] S_RVOL = 4'd8,  S_CALC = 4'd9, S_WP0 = 4'd10, S_WP1 = 4'd11;
    localparam logic [3:0] S_WP2  = 4'd12, S_RSMP = 4'd13, S_OUT = 4'd14;
    localparam logic [7:0] SLOT_LAST = 8'(SLOT_TICKS - 1);

    logic [3:0]  state_reg, pend_reg;
    logic [7:0]  timer_reg;
    logic [2:0]  ch_reg, ch_next_reg, count_reg;
    logic [3:0]  vol_reg;
    logic [7:0]  field_reg [0:6];
    logic [7:0]  smp_byte_reg;
    logic [23:0] phase_new_reg;
    logic [7:0]  nib_reg;
    logic        cpu_ack_reg, cpu_rd_reg;
    logic [7:0]  rdata_hold_reg;
    logic        smp_valid_reg;
    logic [2:0]  smp_ch_reg;
    logic [7:0]  smp_out_reg;

    logic        slot_tick, slot_start, seq_adv, is_read;
    logic [17:0] freq;
    logic [24:0] p_sum;
    logic [8:0]  len_l, p_hi;
    logic [23:0] phase_calc;
    logic [7:0]  nib_calc, smp_byte;
    logic [3:0]  sample;
    logic [2:0]  cnt_eff;
    logic [3:0]  ch_sum;

    assign slot_tick  = m2_ce && (timer_reg == SLOT_LAST);
    assign slot_start = slot_tick && !halt && (state_reg == S_IDLE);
    // Every active state yields to the CPU, so each grant costs exactly one clk.
    assign seq_adv    = (state_reg != S_IDLE) && !cpu_req;
    assign is_read    = ((state_reg >= S_RF0) && (state_reg <= S_RVOL)) || (state_reg == S_RSMP);

    always_comb begin
        freq       = {field_reg[4][1:0], field_reg[2], field_reg[0]};
        p_sum      = {1'b0, field_reg[5], field_reg[3], field_reg[1]} + {7'd0, freq};
        len_l      = 9'd256 - {1'b0, field_reg[4][7:2], 2'b00};
        p_hi       = p_sum[24:16];
        if (p_hi >= len_l) begin
            p_hi = p_hi - len_l;
        end
        phase_calc = {p_hi[7:0], p_sum[15:0]};
        nib_calc   = field_reg[6] + phase_calc[23:16];
        smp_byte   = (pend_reg == S_RSMP) ? ram_rdata : smp_byte_reg;
        sample     = nib_reg[0] ? smp_byte[7:4] : smp_byte[3:0];
        cnt_eff    = (ch_reg == 3'd7) ? ram_rdata[6:4] : count_reg;
        ch_sum     = {1'b0, ch_reg} + {1'b0, cnt_eff};
    end

    // RAM port is combinational so a grant in cycle T has its data back in T+1.
    always_comb begin
        ram_addr  = '0;
        ram_we    = 1'b0;
        ram_wdata = '0;
        if (!reset) begin
            if (cpu_req) begin
                ram_addr  = cpu_addr;
                ram_we    = cpu_we;
                ram_wdata = cpu_we ? cpu_wdata : 8'd0;
            end else if ((state_reg >= S_RF0) && (state_reg <= S_RVOL)) begin
                ram_addr = {1'b1, ch_reg, 3'(state_reg - S_RF0)};
            end else if (state_reg == S_WP0) begin
                ram_addr  = {1'b1, ch_reg, 3'd1};
                ram_we    = 1'b1;
                ram_wdata = phase_new_reg[7:0];
            end else if (state_reg == S_WP1) begin
                ram_addr  = {1'b1, ch_reg, 3'd3};
                ram_we    = 1'b1;
                ram_wdata = phase_new_reg[15:8];
            end else if (state_reg == S_WP2) begin
                ram_addr  = {1'b1, ch_reg, 3'd5};
                ram_we    = 1'b1;
                ram_wdata = phase_new_reg[23:16];
            end else if (state_reg == S_RSMP) begin
                ram_addr = nib_reg[7:1];
            end
        end
    end

    // Read data is captured from whichever cycle follows the issuing grant, even if the CPU holds the port.
    always_ff @(posedge clk) begin
        if ((pend_reg >= S_RF0) && (pend_reg <= S_RWAV)) begin
            field_reg[3'(pend_reg - S_RF0)] <= ram_rdata;
        end
        if (pend_reg == S_RSMP) begin
            smp_byte_reg <= ram_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= S_IDLE;
            pend_reg       <= S_IDLE;
            timer_reg      <= '0;
            ch_reg         <= 3'd7;
            ch_next_reg    <= 3'd7;
            count_reg      <= '0;
            vol_reg        <= '0;
            phase_new_reg  <= '0;
            nib_reg        <= '0;
            cpu_ack_reg    <= 1'b0;
            cpu_rd_reg     <= 1'b0;
            rdata_hold_reg <= '0;
            smp_valid_reg  <= 1'b0;
            smp_ch_reg     <= 3'd7;
            smp_out_reg    <= '0;
        end else begin
            cpu_ack_reg   <= cpu_req;
            cpu_rd_reg    <= cpu_req && !cpu_we;
            smp_valid_reg <= 1'b0;
            pend_reg      <= (seq_adv && is_read) ? state_reg : S_IDLE;
            if (cpu_ack_reg && cpu_rd_reg) begin
                rdata_hold_reg <= ram_rdata;
            end
            if (m2_ce) begin
                timer_reg <= slot_tick ? 8'd0 : timer_reg + 8'd1;
            end
            if (pend_reg == S_RVOL) begin
                vol_reg <= ram_rdata[3:0];
                if (ch_reg == 3'd7) begin
                    count_reg <= ram_rdata[6:4];
                end
                ch_next_reg <= (ch_sum <= 4'd7) ? 3'd7 : ch_reg - 3'd1;
            end
            if (slot_start) begin
                state_reg <= S_RF0;
            end else if (seq_adv) begin
                if (state_reg == S_CALC) begin
                    phase_new_reg <= phase_calc;
                    nib_reg       <= nib_calc;
                end
                if (state_reg == S_OUT) begin
                    smp_valid_reg <= 1'b1;
                    smp_ch_reg    <= ch_reg;
                    smp_out_reg   <= {4'd0, sample} * {4'd0, vol_reg};
                    ch_reg        <= ch_next_reg;
                    state_reg     <= S_IDLE;
                end else begin
                    state_reg <= state_reg + 4'd1;
                end
            end
        end
    end

    assign cpu_ack   = cpu_ack_reg;
    assign cpu_rdata = (cpu_ack_reg && cpu_rd_reg) ? ram_rdata : rdata_hold_reg;
    assign smp_valid = smp_valid_reg;
    assign smp_ch    = smp_ch_reg;
    assign smp_out   = smp_out_reg;
endmodule

// File: tb/tb_n163_wave_sequencer.sv
// Directed bench for n163_wave_sequencer with a behavioural 128x8 synchronous sound RAM.
module tb_n163_wave_sequencer;
    localparam int ST = 15;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       m2_ce = 1'b0;
    logic       halt = 1'b1;
    logic       cpu_req = 1'b0;
    logic       cpu_we = 1'b0;
    logic [6:0] cpu_addr = '0;
    logic [7:0] cpu_wdata = '0;
    logic [7:0] cpu_rdata;
    logic       cpu_ack;
    logic [6:0] ram_addr;
    logic       ram_we;
    logic [7:0] ram_wdata;
    logic [7:0] ram_rdata = '0;
    logic       smp_valid;
    logic [2:0] smp_ch;
    logic [7:0] smp_out;

    logic [7:0] mem [0:127];
    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    int tk = 0;
    int tick_total = 0;
    int start_cyc = 0;
    bit start_seen = 1'b0;

    n163_wave_sequencer #(.SLOT_TICKS(ST)) dut (
        .clk(clk), .reset(reset), .m2_ce(m2_ce), .halt(halt),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .smp_valid(smp_valid), .smp_ch(smp_ch), .smp_out(smp_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    // Reference slot timer: records the cycle index of every slot start.
    always @(posedge clk) begin
        if (reset) begin
            tk = 0;
        end else if (m2_ce) begin
            tick_total = tick_total + 1;
            if (tk == ST - 1) begin
                tk = 0;
                start_cyc = cyc;
                start_seen = 1'b1;
            end else begin
                tk = tk + 1;
            end
        end
        cyc = cyc + 1;
    end

    initial begin
        forever begin
            repeat (11) @(negedge clk);
            m2_ce = 1'b1;
            @(negedge clk);
            m2_ce = 1'b0;
        end
    end

    task automatic cpu_xfer(input logic we, input logic [6:0] addr, input logic [7:0] wd,
                            output logic ack, output logic [7:0] rd);
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
        @(negedge clk);
        ack = cpu_ack; rd = cpu_rdata;
        cpu_req = 1'b0; cpu_we = 1'b0;
        $display("[TB] cpu %s addr=%02h wdata=%02h ack=%0b rdata=%02h", we ? "wr" : "rd", addr, wd, ack, rd);
    endtask

    task automatic wr(input logic [6:0] addr, input logic [7:0] wd);
        logic a; logic [7:0] r;
        cpu_xfer(1'b1, addr, wd, a, r);
    endtask

    task automatic wait_valid(input int max, output bit found, output int at_cyc, output int at_tick);
        found = 1'b0; at_cyc = 0; at_tick = 0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (smp_valid === 1'b1) begin
                found = 1'b1; at_cyc = cyc; at_tick = tick_total;
                $display("[TB] smp ch=%0d out=%0d latency=%0d", smp_ch, smp_out, cyc - start_cyc);
                break;
            end
        end
    endtask

    task automatic wait_start(input int max, output bit found);
        start_seen = 1'b0; found = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (start_seen) begin found = 1'b1; break; end
        end
    endtask

    task automatic test_reset;
        logic [7:0] exp_z = 8'd0;
        tests_run++; if (cpu_ack !== 1'b0)  begin tests_failed++; $display("FAIL reset_cpu_ack got %0b want 0", cpu_ack); end
        tests_run++; if (cpu_rdata !== exp_z) begin tests_failed++; $display("FAIL reset_cpu_rdata got %02h want 00", cpu_rdata); end
        tests_run++; if (ram_we !== 1'b0)   begin tests_failed++; $display("FAIL reset_ram_we got %0b want 0", ram_we); end
        tests_run++; if (ram_addr !== 7'd0) begin tests_failed++; $display("FAIL reset_ram_addr got %02h want 00", ram_addr); end
        tests_run++; if (ram_wdata !== exp_z) begin tests_failed++; $display("FAIL reset_ram_wdata got %02h want 00", ram_wdata); end
        tests_run++; if (smp_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_smp_valid got %0b want 0", smp_valid); end
        tests_run++; if (smp_ch !== 3'd7)   begin tests_failed++; $display("FAIL reset_smp_ch got %0d want 7", smp_ch); end
        tests_run++; if (smp_out !== exp_z) begin tests_failed++; $display("FAIL reset_smp_out got %0d want 0", smp_out); end
    endtask

    task automatic test_single;
        bit f; int c, t; logic a; logic [7:0] r;
        halt = 1'b1;
        wr(7'h78, 8'h00); wr(7'h79, 8'h00); wr(7'h7A, 8'h00); wr(7'h7B, 8'h00);
        wr(7'h7C, 8'hE1); wr(7'h7D, 8'h00); wr(7'h7E, 8'h00); wr(7'h7F, 8'h0F);
        wr(7'h00, 8'h21);
        cpu_xfer(1'b0, 7'h00, 8'h00, a, r);
        tests_run++; if (a !== 1'b1 || r !== 8'h21) begin tests_failed++; $display("FAIL single_cpu_read ack=%0b data=%02h want ack=1 data=21", a, r); end
        halt = 1'b0;
        wait_valid(400, f, c, t);
        halt = 1'b1;
        tests_run++; if (!f) begin tests_failed++; $display("FAIL single_timeout no smp_valid within 400 clk"); end
        tests_run++; if (smp_ch !== 3'd7 || smp_out !== 8'd30) begin tests_failed++; $display("FAIL single_result ch=%0d out=%0d want ch=7 out=30", smp_ch, smp_out); end
        tests_run++; if (c - start_cyc != 15) begin tests_failed++; $display("FAIL single_latency got %0d want 15", c - start_cyc); end
        cpu_xfer(1'b0, 7'h7D, 8'h00, a, r);
        tests_run++; if (r !== 8'h01) begin tests_failed++; $display("FAIL single_phase_hi got %02h want 01", r); end
        cpu_xfer(1'b0, 7'h79, 8'h00, a, r);
        tests_run++; if (r !== 8'h00) begin tests_failed++; $display("FAIL single_phase_lo got %02h want 00", r); end
        cpu_xfer(1'b0, 7'h7B, 8'h00, a, r);
        tests_run++; if (r !== 8'h00) begin tests_failed++; $display("FAIL single_phase_mid got %02h want 00", r); end
    endtask

    task automatic test_wrap;
        bit f; int c, t; logic a; logic [7:0] r;
        wr(7'h7D, 8'd31);
        halt = 1'b0;
        wait_valid(400, f, c, t);
        halt = 1'b1;
        tests_run++; if (!f || smp_out !== 8'd15) begin tests_failed++; $display("FAIL wrap_result found=%0b out=%0d want out=15", f, smp_out); end
        cpu_xfer(1'b0, 7'h7D, 8'h00, a, r);
        tests_run++; if (r !== 8'h00) begin tests_failed++; $display("FAIL wrap_phase_hi got %02h want 00", r); end
    endtask

    task automatic test_contention;
        bit f; int c, t, s; logic a; logic [7:0] r;
        wr(7'h7D, 8'h00);
        halt = 1'b0;
        wait_start(400, f);
        s = start_cyc;
        tests_run++; if (!f) begin tests_failed++; $display("FAIL contention_start_timeout"); end
        for (int g = 0; g < 5; g++) begin
            cpu_xfer(1'b0, 7'h00, 8'h00, a, r);
            tests_run++; if (a !== 1'b1 || r !== 8'h21) begin tests_failed++; $display("FAIL contention_ack%0d ack=%0b data=%02h want ack=1 data=21", g, a, r); end
        end
        wait_valid(60, f, c, t);
        halt = 1'b1;
        tests_run++; if (!f || c - s != 20) begin tests_failed++; $display("FAIL contention_latency found=%0b got %0d want 20", f, c - s); end
        tests_run++; if (smp_ch !== 3'd7 || smp_out !== 8'd30) begin tests_failed++; $display("FAIL contention_result ch=%0d out=%0d want ch=7 out=30", smp_ch, smp_out); end
        cpu_xfer(1'b0, 7'h7D, 8'h00, a, r);
        tests_run++; if (r !== 8'h01) begin tests_failed++; $display("FAIL contention_phase_hi got %02h want 01", r); end
    endtask

    task automatic test_rotation;
        bit f; int c, t, prev_t;
        logic [2:0] exp_ch [0:5];
        logic [7:0] exp_out [0:5];
        exp_ch[0] = 3'd7; exp_ch[1] = 3'd6; exp_ch[2] = 3'd5; exp_ch[3] = 3'd4; exp_ch[4] = 3'd7; exp_ch[5] = 3'd6;
        exp_out[0] = 8'd30; exp_out[1] = 8'd2; exp_out[2] = 8'd0; exp_out[3] = 8'd0; exp_out[4] = 8'd45; exp_out[5] = 8'd2;
        wr(7'h7D, 8'h00); wr(7'h7F, 8'h3F); wr(7'h01, 8'h43); wr(7'h77, 8'h02);
        halt = 1'b0;
        prev_t = 0;
        for (int k = 0; k < 6; k++) begin
            wait_valid(400, f, c, t);
            if (k == 5) halt = 1'b1;
            tests_run++;
            if (!f || smp_ch !== exp_ch[k] || smp_out !== exp_out[k]) begin
                tests_failed++; $display("FAIL rotation_%0d found=%0b ch=%0d out=%0d want ch=%0d out=%0d", k, f, smp_ch, smp_out, exp_ch[k], exp_out[k]);
            end
            if (k > 0) begin
                tests_run++; if (t - prev_t != ST) begin tests_failed++; $display("FAIL rotation_spacing_%0d got %0d ticks want %0d", k, t - prev_t, ST); end
            end
            prev_t = t;
        end
    endtask

    task automatic test_halt;
        bit f; int c, t, extra; logic a; logic [7:0] r;
        halt = 1'b0;
        wait_start(400, f);
        repeat (4) @(negedge clk);
        halt = 1'b1;
        wait_valid(40, f, c, t);
        tests_run++; if (!f || smp_ch !== 3'd5) begin tests_failed++; $display("FAIL halt_last_slot found=%0b ch=%0d want ch=5", f, smp_ch); end
        cpu_xfer(1'b0, 7'h7F, 8'h00, a, r);
        tests_run++; if (a !== 1'b1 || r !== 8'h3F) begin tests_failed++; $display("FAIL halt_cpu_read ack=%0b data=%02h want ack=1 data=3F", a, r); end
        extra = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (smp_valid === 1'b1) extra++;
        end
        tests_run++; if (extra != 0) begin tests_failed++; $display("FAIL halt_idle got %0d pulses want 0", extra); end
    endtask

    task automatic test_reset_wp1;
        bit f; int extra;
        halt = 1'b0;
        wait_start(400, f);
        repeat (10) @(negedge clk);
        tests_run++; if (ram_we !== 1'b1 || ram_addr !== 7'h63) begin tests_failed++; $display("FAIL wp1_write we=%0b addr=%02h want we=1 addr=63", ram_we, ram_addr); end
        reset = 1'b1;
        @(negedge clk);
        tests_run++; if (ram_we !== 1'b0) begin tests_failed++; $display("FAIL wp1_reset_ram_we got %0b want 0", ram_we); end
        reset = 1'b0;
        test_reset();
        extra = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (smp_valid === 1'b1) extra++;
        end
        tests_run++; if (extra != 0) begin tests_failed++; $display("FAIL wp1_abort got %0d pulses want 0", extra); end
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        test_reset();
        test_single();
        test_wrap();
        test_contention();
        test_rotation();
        test_halt();
        test_reset_wp1();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
